// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, data-bit-count encoding and divider width,
// common to uart_rx and uart_tx.
package uart_pkg;

  localparam int DIV_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_e;

  typedef enum logic [1:0] {
    BITS_5 = 2'd0,
    BITS_6 = 2'd1,
    BITS_7 = 2'd2,
    BITS_8 = 2'd3
  } uart_bits_e;

  // Index of the final data bit of a frame for a given bit-count encoding.
  function automatic logic [2:0] last_bit_idx(input logic [1:0] bits);
    logic [2:0] idx;
    case (uart_bits_e'(bits))
      BITS_5:  idx = 3'd4;
      BITS_6:  idx = 3'd5;
      BITS_7:  idx = 3'd6;
      default: idx = 3'd7;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/uart_sync.sv
// Multi-flop synchronizer for an asynchronous serial line; resets to the idle
// (high) level so that reset release never looks like a start bit.
module uart_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic d_i,
  output logic q_o
);

  logic [SYNC_STAGES-1:0] sync_reg;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sync_reg <= '1;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_reg[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver: mid-bit sampling, 5..8 data bits, optional even parity, 1 or 2
// stop bits, one-word holding register. Define UART_RX_FRAME_ERR_EN to flag low stop samples.
module uart_rx
  import uart_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             rx_i,
  input  logic             cfg_en_i,
  input  logic [DIV_W-1:0] cfg_div_i,
  input  logic             cfg_parity_en_i,
  input  logic [1:0]       cfg_bits_i,
  input  logic             cfg_stop_bits_i,
  output logic [7:0]       rx_data_o,
  output logic             rx_valid_o,
  input  logic             rx_ready_i,
  output logic             rx_err_o,
  output logic             overrun_o,
  output logic             busy_o
);

  uart_state_e state_reg, state_next;

  logic             rx_sync;
  logic             rx_prev_reg;
  logic [DIV_W-1:0] cnt_reg;
  logic [2:0]       bit_idx_reg;
  logic             stop_idx_reg;
  logic [7:0]       shift_reg;
  logic             parity_reg;
  logic             done_reg;
  logic [7:0]       word_reg;
  logic             word_err_reg;
  logic [7:0]       data_reg;
  logic             valid_reg;
  logic             err_reg;
  logic             overrun_reg;

  logic sample_point;
  logic last_data;
  logic last_stop;
  logic start_detect;
  logic sample_start;
  logic sample_data;
  logic sample_parity;
  logic sample_stop;
  logic frame_end;
  logic stop_err;

  uart_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .d_i    (rx_i),
    .q_o    (rx_sync)
  );

  // Start bit is sampled half a bit in; every later bit a full period after that.
  always_comb begin
    sample_point = 1'b0;
    case (state_reg)
      ST_START:                    sample_point = (cnt_reg == {1'b0, cfg_div_i[DIV_W-1:1]});
      ST_DATA, ST_PARITY, ST_STOP: sample_point = (cnt_reg == cfg_div_i);
      default:                     sample_point = 1'b0;
    endcase
  end

  assign last_data = (bit_idx_reg == last_bit_idx(cfg_bits_i));
  assign last_stop = (stop_idx_reg == cfg_stop_bits_i);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (!cfg_en_i) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE:   if (start_detect) state_next = ST_START;
        ST_START:  if (sample_start) state_next = rx_sync ? ST_IDLE : ST_DATA;
        ST_DATA:   if (sample_data && last_data) state_next = cfg_parity_en_i ? ST_PARITY : ST_STOP;
        ST_PARITY: if (sample_parity) state_next = ST_STOP;
        ST_STOP:   if (frame_end) state_next = ST_IDLE;
        default:   state_next = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    busy_o        = (state_reg != ST_IDLE);
    start_detect  = cfg_en_i && (state_reg == ST_IDLE) && rx_prev_reg && !rx_sync;
    sample_start  = cfg_en_i && (state_reg == ST_START) && sample_point;
    sample_data   = cfg_en_i && (state_reg == ST_DATA) && sample_point;
    sample_parity = cfg_en_i && (state_reg == ST_PARITY) && sample_point;
    sample_stop   = cfg_en_i && (state_reg == ST_STOP) && sample_point;
    frame_end     = sample_stop && last_stop;
  end

`ifdef UART_RX_FRAME_ERR_EN
  logic ferr_reg;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      ferr_reg <= 1'b0;
    end else if (start_detect) begin
      ferr_reg <= 1'b0;
    end else if (sample_stop && !rx_sync) begin
      ferr_reg <= 1'b1;
    end
  end

  // Includes the sample being taken right now (the final stop bit).
  assign stop_err = ferr_reg | ~rx_sync;
`else
  assign stop_err = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rx_prev_reg  <= 1'b1;
      cnt_reg      <= '0;
      bit_idx_reg  <= '0;
      stop_idx_reg <= 1'b0;
      shift_reg    <= '0;
      parity_reg   <= 1'b0;
      done_reg     <= 1'b0;
      word_reg     <= '0;
      word_err_reg <= 1'b0;
    end else begin
      rx_prev_reg <= rx_sync;
      done_reg    <= frame_end;
      cnt_reg     <= (state_reg == ST_IDLE || sample_point) ? '0 : cnt_reg + 1'b1;
      if (start_detect) begin
        shift_reg    <= '0;
        bit_idx_reg  <= '0;
        stop_idx_reg <= 1'b0;
        parity_reg   <= 1'b0;
      end
      if (sample_data) begin
        shift_reg[bit_idx_reg] <= rx_sync;
        parity_reg             <= parity_reg ^ rx_sync;
        bit_idx_reg            <= bit_idx_reg + 3'd1;
      end
      if (sample_parity) begin
        parity_reg <= parity_reg ^ rx_sync;
      end
      if (sample_stop) begin
        stop_idx_reg <= 1'b1;
      end
      if (frame_end) begin
        word_reg     <= shift_reg;
        word_err_reg <= (cfg_parity_en_i & parity_reg) | stop_err;
      end
    end
  end

  // Holding register: a completed frame loads unless an unconsumed word blocks it.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      data_reg    <= '0;
      valid_reg   <= 1'b0;
      err_reg     <= 1'b0;
      overrun_reg <= 1'b0;
    end else begin
      overrun_reg <= 1'b0;
      if (done_reg) begin
        if (valid_reg && !rx_ready_i) begin
          overrun_reg <= 1'b1;
        end else begin
          data_reg  <= word_reg;
          err_reg   <= word_err_reg;
          valid_reg <= 1'b1;
        end
      end else if (valid_reg && rx_ready_i) begin
        valid_reg <= 1'b0;
      end
    end
  end

  assign rx_data_o  = data_reg;
  assign rx_valid_o = valid_reg;
  assign rx_err_o   = err_reg;
  assign overrun_o  = overrun_reg;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed vector table, hand-written corner
// sequences and randomized frames checked against a frame-level reference model.
module tb_uart_rx;

  localparam int SYNC = 2;
`ifdef UART_RX_FRAME_ERR_EN
  localparam bit FE = 1'b1;
`else
  localparam bit FE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rstn;
  logic        rx;
  logic        en;
  logic [15:0] div;
  logic        par_en;
  logic [1:0]  bits;
  logic        stop2;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        ready;
  logic        rx_err;
  logic        overrun;
  logic        busy;

  always #5 clk = ~clk;

  uart_rx #(.SYNC_STAGES(SYNC)) dut (
    .clk_i           (clk),
    .rstn_i          (rstn),
    .rx_i            (rx),
    .cfg_en_i        (en),
    .cfg_div_i       (div),
    .cfg_parity_en_i (par_en),
    .cfg_bits_i      (bits),
    .cfg_stop_bits_i (stop2),
    .rx_data_o       (rx_data),
    .rx_valid_o      (rx_valid),
    .rx_ready_i      (ready),
    .rx_err_o        (rx_err),
    .overrun_o       (overrun),
    .busy_o          (busy)
  );

  typedef struct {
    logic [7:0] data;
    logic       err;
  } word_t;

  typedef struct {
    int         dv;
    int         nb;
    bit         pe;
    bit         s2;
    logic [7:0] d;
    bit         flip;
    bit         slow;
    logic [7:0] exp_data;
    bit         exp_err_nofe;
    bit         exp_err_fe;
  } vec_t;

  int    n_checks = 0;
  int    n_fail = 0;
  int    cyc = 0;
  int    busy_rise = 0;
  int    busy_fall = 0;
  int    valid_rise = 0;
  int    ovr_cnt = 0;
  logic  busy_q = 1'b0;
  logic  valid_q = 1'b0;
  word_t got_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Passive monitor: accepted words, overrun pulses and edge times of busy/valid.
  always @(negedge clk) begin
    busy_q  <= busy;
    valid_q <= rx_valid;
    if (rstn) begin
      if (busy && !busy_q) busy_rise <= cyc;
      if (!busy && busy_q) busy_fall <= cyc;
      if (rx_valid && !valid_q) valid_rise <= cyc;
      if (overrun) ovr_cnt <= ovr_cnt + 1;
      if (rx_valid && ready) got_q.push_back('{rx_data, rx_err});
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_cfg(input int dv, input int nb, input bit pe, input bit s2);
    div    = 16'(dv);
    bits   = 2'(nb - 5);
    par_en = pe;
    stop2  = s2;
  endtask

  task automatic send_frame(input logic [7:0] d, input int nb, input bit pe, input bit s2,
                            input bit flip, input bit slow, input int dv);
    logic p;
    p  = 1'b0;
    rx = 1'b0;
    tick(dv + 1);
    for (int i = 0; i < nb; i++) begin
      rx = d[i];
      p  = p ^ d[i];
      tick(dv + 1);
    end
    if (pe) begin
      rx = p ^ flip;
      tick(dv + 1);
    end
    rx = ~slow;
    tick(dv + 1);
    if (s2) begin
      rx = 1'b1;
      tick(dv + 1);
    end
    rx = 1'b1;
  endtask

  task automatic wait_words(input int n, input int budget);
    int k;
    k = 0;
    while (got_q.size() < n && k < budget) begin
      tick(1);
      k++;
    end
    check("word_count", got_q.size(), n);
  endtask

  // Reference: what a correct receiver reports for a frame, from the framing rules.
  function automatic word_t model(input logic [7:0] d, input int nb, input bit pe,
                                  input bit flip, input bit slow);
    word_t w;
    logic [7:0] masked;
    logic sent_par;
    masked   = d & 8'((1 << nb) - 1);
    sent_par = (^masked) ^ flip;
    w.data   = masked;
    w.err    = (pe && ((^masked) ^ sent_par)) || (FE && slow);
    return w;
  endfunction

  vec_t  tbl[7];
  word_t w;
  word_t e;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{16, 8, 1'b1, 1'b0, 8'h08, 1'b0, 1'b0, 8'h08, 1'b0, 1'b0};
    tbl[1] = '{16, 5, 1'b0, 1'b1, 8'h15, 1'b0, 1'b0, 8'h15, 1'b0, 1'b0};
    tbl[2] = '{16, 8, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b1};
    tbl[3] = '{16, 8, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b1};
    tbl[4] = '{10, 6, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, 8'h3F, 1'b0, 1'b0};
    tbl[5] = '{7,  7, 1'b1, 1'b0, 8'h80, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[6] = '{5,  7, 1'b1, 1'b1, 8'h55, 1'b1, 1'b1, 8'h55, 1'b1, 1'b1};

    rstn  = 1'b0;
    rx    = 1'b1;
    en    = 1'b1;
    ready = 1'b1;
    set_cfg(16, 8, 1'b0, 1'b0);
    tick(3);
    check("reset_data", rx_data, 8'h00);
    check("reset_valid", rx_valid, 1'b0);
    check("reset_err", rx_err, 1'b0);
    check("reset_overrun", overrun, 1'b0);
    check("reset_busy", busy, 1'b0);
    rstn = 1'b1;
    tick(5);

    // Directed vectors, including frame timing relative to start detection.
    for (int v = 0; v < 7; v++) begin
      int exp_lat;
      set_cfg(tbl[v].dv, tbl[v].nb, tbl[v].pe, tbl[v].s2);
      tick(3);
      send_frame(tbl[v].d, tbl[v].nb, tbl[v].pe, tbl[v].s2, tbl[v].flip, tbl[v].slow, tbl[v].dv);
      tick(4);
      wait_words(1, 200);
      if (got_q.size() > 0) begin
        w = got_q.pop_front();
        check($sformatf("vec%0d_data", v), w.data, tbl[v].exp_data);
        check($sformatf("vec%0d_err", v), w.err, FE ? tbl[v].exp_err_fe : tbl[v].exp_err_nofe);
      end
      exp_lat = (tbl[v].dv >> 1) + 1
              + (tbl[v].nb + int'(tbl[v].pe) + 1 + int'(tbl[v].s2)) * (tbl[v].dv + 1) + 1;
      check($sformatf("vec%0d_valid_latency", v), valid_rise - busy_rise, exp_lat);
      check($sformatf("vec%0d_busy_len", v), busy_fall - busy_rise, exp_lat - 1);
      $display("vector %0d: data 0x%02h done", v, tbl[v].d);
    end

    // Short low glitch: START only, then back to idle without a word.
    set_cfg(16, 8, 1'b0, 1'b0);
    tick(3);
    rx = 1'b0;
    tick(4);
    rx = 1'b1;
    check("glitch_busy_high", busy, 1'b1);
    tick(30);
    check("glitch_busy_low", busy, 1'b0);
    check("glitch_no_word", got_q.size(), 0);
    check("glitch_no_valid", rx_valid, 1'b0);
    $display("glitch: done");

    // Overrun: second frame arrives while the first is still held.
    begin
      int ovr_base;
      ovr_base = ovr_cnt;
      ready = 1'b0;
      send_frame(8'h11, 8, 1'b0, 1'b0, 1'b0, 1'b0, 16);
      tick(4);
      check("ovr_first_valid", rx_valid, 1'b1);
      check("ovr_first_data", rx_data, 8'h11);
      send_frame(8'h22, 8, 1'b0, 1'b0, 1'b0, 1'b0, 16);
      tick(4);
      check("ovr_kept_data", rx_data, 8'h11);
      check("ovr_still_valid", rx_valid, 1'b1);
      check("ovr_pulses", ovr_cnt - ovr_base, 1);
      ready = 1'b1;
      tick(2);
      wait_words(1, 10);
      if (got_q.size() > 0) begin
        w = got_q.pop_front();
        check("ovr_retired_data", w.data, 8'h11);
      end
      check("ovr_valid_cleared", rx_valid, 1'b0);
      $display("overrun: done");
    end

    // Reset in the middle of data bit 3, then a clean frame.
    rx = 1'b0;
    tick(17);
    for (int i = 0; i < 3; i++) begin
      rx = ((8'h5A >> i) & 8'h01) != 0;
      tick(17);
    end
    rx = 1'b1;
    tick(8);
    check("midrst_busy_before", busy, 1'b1);
    rstn = 1'b0;
    #1;
    check("midrst_data", rx_data, 8'h00);
    check("midrst_valid", rx_valid, 1'b0);
    check("midrst_err", rx_err, 1'b0);
    check("midrst_overrun", overrun, 1'b0);
    check("midrst_busy", busy, 1'b0);
    tick(3);
    rstn = 1'b1;
    tick(20);
    check("midrst_idle", busy, 1'b0);
    check("midrst_no_word", got_q.size(), 0);
    send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b0, 1'b0, 16);
    tick(4);
    wait_words(1, 200);
    if (got_q.size() > 0) begin
      w = got_q.pop_front();
      check("postrst_data", w.data, 8'h5A);
      check("postrst_err", w.err, 1'b0);
    end
    $display("mid-frame reset: done");

    // Receiver disable mid-frame aborts without output.
    rx = 1'b0;
    tick(17);
    rx = 1'b1;
    tick(17);
    en = 1'b0;
    tick(2);
    check("disable_busy", busy, 1'b0);
    en = 1'b1;
    tick(170);
    check("disable_no_word", got_q.size(), 0);
    check("disable_no_valid", rx_valid, 1'b0);
    $display("disable abort: done");

    // Randomized frames against the reference model.
    for (int t = 0; t < 25; t++) begin
      int dv, nb;
      bit pe, s2, flip, slow;
      logic [7:0] d;
      dv   = $urandom_range(3, 24);
      nb   = $urandom_range(5, 8);
      pe   = 1'($urandom_range(0, 1));
      s2   = 1'($urandom_range(0, 1));
      flip = 1'($urandom_range(0, 1));
      slow = ($urandom_range(0, 3) == 0);
      d    = 8'($urandom);
      set_cfg(dv, nb, pe, s2);
      tick(2);
      send_frame(d, nb, pe, s2, flip, slow, dv);
      tick($urandom_range(3, 8));
      wait_words(1, 200);
      e = model(d, nb, pe, flip, slow);
      if (got_q.size() > 0) begin
        w = got_q.pop_front();
        check($sformatf("rand%0d_data", t), w.data, e.data);
        check($sformatf("rand%0d_err", t), w.err, e.err);
      end
      $display("random %0d: div %0d bits %0d par %0d stop2 %0d data 0x%02h exp 0x%02h err %0d",
               t, dv, nb, pe, s2, d, e.data, e.err);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter SYNC_STAGES, default 2: number of flip-flops in the rx_i input synchronizer (minimum 2).
REQ-002 clk_i  input  1  system clock; all logic on the rising edge.
REQ-003 rstn_i  input  1  asynchronous, active-low reset.
REQ-004 rx_i  input  1  serial line; idle high.
REQ-005 cfg_en_i  input  1  receiver enable.
REQ-006 cfg_div_i  input  16  baud divider; bit period = cfg_div_i+1 clocks, same as uart_tx.
REQ-007 cfg_parity_en_i  input  1  even parity bit present after the data bits.
REQ-008 cfg_bits_i  input  2  data bits = 5+cfg_bits_i (00=5 ... 11=8).
REQ-009 cfg_stop_bits_i  input  1  0 = one stop bit, 1 = two stop bits.
REQ-010 rx_data_o  output  8  received word, LSB-aligned, unused upper bits zero.
REQ-011 rx_valid_o  output  1  rx_data_o/rx_err_o hold a word.
REQ-012 rx_ready_i  input  1  consumer accepts the word.
REQ-013 rx_err_o  output  1  parity (and, if enabled, framing) error for the held word.
REQ-014 overrun_o  output  1  one-cycle pulse: frame completed while the previous word was unconsumed.
REQ-015 busy_o  output  1  high from start-bit detection until the end of the last stop-bit sample.

Function
REQ-016 rx_i SHALL pass through SYNC_STAGES flops; all detection uses the synchronized value.
REQ-017 FSM states SHALL be IDLE, START, DATA, PARITY, STOP; transitions only at sample points, except the abort cases below.
REQ-018 IDLE: a high-to-low transition of the synchronized line SHALL enter START and clear the baud counter.
REQ-019 START: after (cfg_div_i>>1)+1 clocks the line SHALL be sampled; low -> DATA with counter cleared; high -> glitch, return to IDLE, no output.
REQ-020 DATA/PARITY/STOP: each bit SHALL be sampled cfg_div_i+1 clocks after the previous sample (mid-bit).
REQ-021 Data SHALL be shifted in LSB first; after 5+cfg_bits_i bits go to PARITY if cfg_parity_en_i, else STOP.
REQ-022 Parity error SHALL be set when XOR of the data bits and the parity bit is 1 (even parity).
REQ-023 STOP: one sample, or two when cfg_stop_bits_i=1; then IDLE, able to detect a new start bit on the following clock.
REQ-024 rx_valid_o SHALL rise on the clock after the final stop-bit sample and stay high until a cycle with rx_valid_o && rx_ready_i; data and error remain stable meanwhile.
REQ-025 If a frame completes while rx_valid_o is high and rx_ready_i is low, the new word SHALL be dropped, the old word kept, and overrun_o pulsed.
REQ-026 If rx_ready_i is high in the completion cycle of a new frame, the handshake SHALL retire the old word and the new word SHALL load (no overrun).
REQ-027 cfg_en_i low SHALL force IDLE at the next clock, aborting any frame without output; the held word and rx_valid_o are unaffected.
REQ-028 Configuration inputs SHALL be changed only while busy_o is low; behaviour otherwise is undefined.
REQ-029 cfg_div_i values below 3 are unsupported.

Reset
REQ-030 rstn_i low SHALL asynchronously force IDLE, clear the counter and shift register, and set rx_data_o=0, rx_valid_o=0, rx_err_o=0, overrun_o=0, busy_o=0; synchronizer flops reset to 1.
REQ-031 Reset mid-frame SHALL discard the frame; after release, reception resumes only on a new falling edge.

Configuration
REQ-032 Macro UART_RX_FRAME_ERR_EN defined: a low sample at any stop-bit position SHALL set rx_err_o for that word; undefined: stop samples are ignored and rx_err_o reflects parity only.

Structure
REQ-033 Package uart_pkg SHALL hold the FSM state enum, the data-bit-count encoding for cfg_bits_i, and the 16-bit divider width constant, shared with uart_tx.
REQ-034 The synchronizer SHALL be sub-module uart_sync (parameter SYNC_STAGES, reset value 1).

Verification
REQ-035 div=16, 8 bits, parity on, 1 stop, uart_tx loopback with 0x08 -> one rx_valid_o, rx_data_o=0x08, rx_err_o=0.
REQ-036 div=16, 5 bits, no parity, 2 stops, serial 0x15 -> rx_data_o=0x15, rx_valid_o asserted 2 bit periods after the last data-bit sample +1 clock.
REQ-037 Parity bit inverted on 0xA5 -> rx_data_o=0xA5, rx_err_o=1; with UART_RX_FRAME_ERR_EN, stop bit driven low on 0x3C -> rx_err_o=1.
REQ-038 Low glitch of 4 clocks at div=16 -> no state change beyond START, busy_o returns low, no rx_valid_o.
REQ-039 rx_ready_i held low over two frames 0x11 then 0x22 -> rx_data_o stays 0x11, overrun_o pulses once.
REQ-040 rstn_i asserted during data bit 3 -> all outputs zero immediately; next full frame 0x5A received correctly.
